// File: rtl/paddle_control.sv
// Paddle controller: erases, moves and redraws a horizontal paddle in response to
// frame ticks, streaming pixel writes to a VGA adapter through a small x/y datapath.
module paddle_control #(
  parameter int          PADDLE_W      = 16,
  parameter int          PADDLE_H      = 2,
  parameter int          STEP          = 2,
  parameter int          X_MAX         = 160,
  parameter int          PADDLE_Y      = 110,
  parameter logic [2:0]  PADDLE_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       move_left,
  input  logic       move_right,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic       ld_x,
  output logic       ld_y,
  output logic [4:0] counter_x,
  output logic [4:0] counter_y,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic [7:0] paddle_x
);

  typedef enum logic [2:0] {
    INIT, IDLE, LOAD_ERASE, ERASE, UPDATE, LOAD_DRAW, DRAW
  } state_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [8:0] X_LIMIT = 9'(X_MAX - PADDLE_W);
  localparam logic [7:0] X_START = 8'((X_MAX - PADDLE_W) / 2);
  localparam logic [8:0] STEP9   = 9'(STEP);
  localparam logic [4:0] CX_LAST = 5'(PADDLE_W - 1);
  localparam logic [4:0] CY_LAST = 5'(PADDLE_H - 1);

  state_t     state, state_next;
  dir_t       dir, dir_next, req_dir;
  logic [7:0] x_next;
  logic [4:0] cx_next, cy_next;
  logic       ld;

  // Clamped target position; 9-bit arithmetic keeps x+STEP from wrapping.
  function automatic logic [7:0] moved(input dir_t d, input logic [7:0] x);
    logic [8:0] wide;
    moved = x;
    wide  = {1'b0, x};
    case (d)
      DIR_LEFT:  moved = (wide >= STEP9) ? 8'(wide - STEP9) : 8'd0;
      DIR_RIGHT: begin
        wide  = wide + STEP9;
        moved = (wide > X_LIMIT) ? X_LIMIT[7:0] : wide[7:0];
      end
      default:   moved = x;
    endcase
  endfunction

  always_comb begin
    req_dir = DIR_NONE;
    if (move_left && !move_right)
      req_dir = DIR_LEFT;
    else if (move_right && !move_left)
      req_dir = DIR_RIGHT;
  end

  always_comb begin
    state_next = state;
    dir_next   = dir;
    x_next     = paddle_x;
    cx_next    = counter_x;
    cy_next    = counter_y;
    case (state)
      INIT:       state_next = LOAD_DRAW;
      IDLE: begin
        if (tick) begin
          dir_next = req_dir;
          if (moved(req_dir, paddle_x) != paddle_x)
            state_next = LOAD_ERASE;
        end
      end
      LOAD_ERASE: state_next = ERASE;
      ERASE, DRAW: begin
        if (counter_x == CX_LAST) begin
          cx_next = 5'd0;
          if (counter_y == CY_LAST) begin
            cy_next    = 5'd0;
            state_next = (state == ERASE) ? UPDATE : IDLE;
          end else begin
            cy_next = counter_y + 5'd1;
          end
        end else begin
          cx_next = counter_x + 5'd1;
        end
      end
      UPDATE: begin
        x_next     = moved(dir, paddle_x);
        state_next = LOAD_DRAW;
      end
      LOAD_DRAW:  state_next = DRAW;
      default:    state_next = INIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      dir       <= DIR_NONE;
      paddle_x  <= X_START;
      counter_x <= 5'd0;
      counter_y <= 5'd0;
      plot      <= 1'b0;
      colour    <= 3'b000;
      ld        <= 1'b1;
      busy      <= 1'b1;
    end else begin
      state     <= state_next;
      dir       <= dir_next;
      paddle_x  <= x_next;
      counter_x <= cx_next;
      counter_y <= cy_next;
      plot      <= (state_next == ERASE) || (state_next == DRAW);
      colour    <= (state_next == DRAW) ? PADDLE_COLOUR : 3'b000;
      ld        <= !((state_next == LOAD_ERASE) || (state_next == LOAD_DRAW));
      busy      <= (state_next != IDLE);
    end
  end

  assign x_out = paddle_x;
  assign y_out = 7'(PADDLE_Y);
  assign ld_x  = ld;
  assign ld_y  = ld;

endmodule
